// File: rtl/serial_mmio_pkg.sv
// Shared constants for the serial MMIO block: register addresses, default
// transmit gap (shared with the monitor's DUMPWAIT) and drain FSM encoding.
package serial_mmio_pkg;

   localparam int unsigned DATA_ADDR_DEF   = 256;
   localparam int unsigned STAT_ADDR_DEF   = 257;
   localparam int unsigned TXSTAT_ADDR_DEF = 258;

   localparam int unsigned DUMPWAIT = 4095;

   localparam logic [1:0] DRAIN_IDLE  = 2'd0;
   localparam logic [1:0] DRAIN_LOAD  = 2'd1;
   localparam logic [1:0] DRAIN_GAP   = 2'd2;
   localparam logic [1:0] DRAIN_WAITU = 2'd3;

endpackage

// File: rtl/serial_tx_pacer.sv
// Drains the transmit FIFO into the UART, one byte per GAP_CYCLES+2 cycles.
// GAP_CYCLES must be at least 2.
module serial_tx_pacer
   import serial_mmio_pkg::*;
#(
   parameter int unsigned GAP_CYCLES = DUMPWAIT
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic       enable,
   input  logic       tx_empty,
   input  logic [7:0] tx_dout,
   output logic       tx_read,
   input  logic       u_is_transmitting,
   output logic       u_transmit,
   output logic [7:0] u_tx_byte
);

   localparam int unsigned CW = $clog2(GAP_CYCLES + 1);
   // LOAD, WAITU and IDLE each cost one cycle, so the GAP phase is trimmed
   // to keep the start-to-start spacing at exactly GAP_CYCLES+2.
   localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 2);

   logic [1:0]    state;
   logic [CW-1:0] cnt;

   always_ff @(posedge CLK) begin
      if (!reset) begin
         state      <= DRAIN_IDLE;
         cnt        <= '0;
         tx_read    <= 1'b0;
         u_transmit <= 1'b0;
         u_tx_byte  <= '0;
      end else begin
         tx_read    <= 1'b0;
         u_transmit <= 1'b0;
         case (state)
            DRAIN_IDLE:
               if (enable && !tx_empty && !u_is_transmitting)
                  state <= DRAIN_LOAD;
            DRAIN_LOAD: begin
               u_tx_byte  <= tx_dout;
               tx_read    <= 1'b1;
               u_transmit <= 1'b1;
               cnt        <= GAP_LOAD;
               state      <= DRAIN_GAP;
            end
            DRAIN_GAP:
               if (cnt == '0)
                  state <= DRAIN_WAITU;
               else
                  cnt <= cnt - CW'(1);
            DRAIN_WAITU:
               if (!u_is_transmitting)
                  state <= DRAIN_IDLE;
            default:
               state <= DRAIN_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/serial_mmio.sv
// Memory-mapped serial port: RX holding register, TX FIFO push, paced UART drain.
// Optional TX status register at STAT_ADDR+1 when SERIAL_MMIO_TXSTAT_EN is defined.
module serial_mmio
   import serial_mmio_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 18,
   parameter int unsigned DATA_ADDR  = DATA_ADDR_DEF,
   parameter int unsigned STAT_ADDR  = STAT_ADDR_DEF,
   parameter int unsigned GAP_CYCLES = DUMPWAIT
) (
   input  logic                  CLK,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [ADDR_WIDTH-1:0] cpu_raddr,
   input  logic [ADDR_WIDTH-1:0] cpu_waddr,
   input  logic                  cpu_write,
   input  logic [7:0]            cpu_wdata,
   output logic                  rd_override,
   output logic [7:0]            rd_data,
   input  logic                  rx_empty,
   input  logic [7:0]            rx_dout,
   output logic                  rx_read,
   input  logic                  tx_full,
   output logic                  tx_write,
   output logic [7:0]            tx_din,
   input  logic                  tx_empty,
   input  logic [7:0]            tx_dout,
   output logic                  tx_read,
   input  logic                  u_is_transmitting,
   output logic                  u_transmit,
   output logic [7:0]            u_tx_byte
);

   localparam logic [ADDR_WIDTH-1:0] A_DATA = ADDR_WIDTH'(DATA_ADDR);
   localparam logic [ADDR_WIDTH-1:0] A_STAT = ADDR_WIDTH'(STAT_ADDR);
`ifdef SERIAL_MMIO_TXSTAT_EN
   localparam logic [ADDR_WIDTH-1:0] A_TXST = ADDR_WIDTH'(STAT_ADDR + 1);
   logic overflow;
`endif

   logic [7:0] hold;
   logic       avail;
   logic       clr;
   logic       push_req;

   assign clr      = cpu_write && (cpu_waddr == A_STAT);
   assign push_req = cpu_write && (cpu_waddr == A_DATA) && enable;

   always_ff @(posedge CLK) begin
      if (!reset) begin
         hold        <= '0;
         avail       <= 1'b0;
         rx_read     <= 1'b0;
         tx_write    <= 1'b0;
         tx_din      <= '0;
         rd_override <= 1'b0;
         rd_data     <= '0;
`ifdef SERIAL_MMIO_TXSTAT_EN
         overflow    <= 1'b0;
`endif
      end else begin
         rx_read  <= 1'b0;
         tx_write <= 1'b0;

         // Clear beats fill; avail gates the pop so the FIFO's empty-flag lag
         // can never cause a second pop.
         if (!enable || clr)
            avail <= 1'b0;
         else if (!rx_empty && !avail) begin
            hold    <= rx_dout;
            rx_read <= 1'b1;
            avail   <= 1'b1;
         end

         if (push_req && !tx_full) begin
            tx_write <= 1'b1;
            tx_din   <= cpu_wdata;
         end
`ifdef SERIAL_MMIO_TXSTAT_EN
         if (push_req && tx_full)
            overflow <= 1'b1;
         else if (cpu_write && (cpu_waddr == A_TXST))
            overflow <= 1'b0;
`endif

         if (cpu_raddr == A_DATA) begin
            rd_override <= 1'b1;
            rd_data     <= hold;
         end else if (cpu_raddr == A_STAT) begin
            rd_override <= 1'b1;
            rd_data     <= {7'b0, avail};
`ifdef SERIAL_MMIO_TXSTAT_EN
         end else if (cpu_raddr == A_TXST) begin
            rd_override <= 1'b1;
            rd_data     <= {5'b0, overflow, tx_full, tx_empty};
`endif
         end else begin
            rd_override <= 1'b0;
            rd_data     <= '0;
         end
      end
   end

   serial_tx_pacer #(
      .GAP_CYCLES(GAP_CYCLES)
   ) u_pacer (
      .CLK              (CLK),
      .reset            (reset),
      .enable           (enable),
      .tx_empty         (tx_empty),
      .tx_dout          (tx_dout),
      .tx_read          (tx_read),
      .u_is_transmitting(u_is_transmitting),
      .u_transmit       (u_transmit),
      .u_tx_byte        (u_tx_byte)
   );

endmodule

// File: tb/tb_serial_mmio.sv
// Self-checking bench for serial_mmio: cycle vector table for the register path,
// hand-written sequences for pacing, enable drop and reset mid-drain.
module tb_serial_mmio;

   localparam int unsigned GAP = 10;

`ifdef SERIAL_MMIO_TXSTAT_EN
   localparam bit TXSTAT = 1'b1;
`else
   localparam bit TXSTAT = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        reset;
   logic        enable;
   logic [17:0] cpu_raddr;
   logic [17:0] cpu_waddr;
   logic        cpu_write;
   logic [7:0]  cpu_wdata;
   logic        rd_override;
   logic [7:0]  rd_data;
   logic        rx_empty;
   logic [7:0]  rx_dout;
   logic        rx_read;
   logic        tx_full;
   logic        tx_write;
   logic [7:0]  tx_din;
   logic        tx_empty;
   logic [7:0]  tx_dout;
   logic        tx_read;
   logic        u_is_transmitting;
   logic        u_transmit;
   logic [7:0]  u_tx_byte;

   serial_mmio #(
      .ADDR_WIDTH(18),
      .DATA_ADDR (256),
      .STAT_ADDR (257),
      .GAP_CYCLES(GAP)
   ) dut (
      .CLK              (CLK),
      .reset            (reset),
      .enable           (enable),
      .cpu_raddr        (cpu_raddr),
      .cpu_waddr        (cpu_waddr),
      .cpu_write        (cpu_write),
      .cpu_wdata        (cpu_wdata),
      .rd_override      (rd_override),
      .rd_data          (rd_data),
      .rx_empty         (rx_empty),
      .rx_dout          (rx_dout),
      .rx_read          (rx_read),
      .tx_full          (tx_full),
      .tx_write         (tx_write),
      .tx_din           (tx_din),
      .tx_empty         (tx_empty),
      .tx_dout          (tx_dout),
      .tx_read          (tx_read),
      .u_is_transmitting(u_is_transmitting),
      .u_transmit       (u_transmit),
      .u_tx_byte        (u_tx_byte)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        en, rxe, wr, txf;
      logic [7:0]  rxd, wd;
      logic [17:0] ra, wa;
      logic        e_rxr, e_ovr, e_txw;
      logic [7:0]  e_rd, e_din;
   } vec_t;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   logic [7:0]  txq[$];
   int          pt[$];
   logic [7:0]  pb[$];

   function automatic vec_t mk(input int en, rxe, rxd, ra, wr, wa, wd, txf,
                               input int e_rxr, e_ovr, e_rd, e_txw, e_din);
      vec_t v;
      v.en = 1'(en); v.rxe = 1'(rxe); v.rxd = 8'(rxd); v.ra = 18'(ra);
      v.wr = 1'(wr); v.wa = 18'(wa); v.wd = 8'(wd); v.txf = 1'(txf);
      v.e_rxr = 1'(e_rxr); v.e_ovr = 1'(e_ovr); v.e_rd = 8'(e_rd);
      v.e_txw = 1'(e_txw); v.e_din = 8'(e_din);
      return v;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic void fifo_sync();
      tx_empty = (txq.size() == 0);
      tx_dout  = tx_empty ? 8'h00 : txq[0];
   endfunction

   // One clock; sample 1 time unit after the edge and update the TX FIFO model.
   task automatic cycle();
      @(posedge CLK);
      #1;
      cyc++;
      if (tx_read && txq.size() > 0) void'(txq.pop_front());
      fifo_sync();
   endtask

   task automatic wait_tx(input int budget, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         cycle();
         if (u_transmit) seen = 1'b1;
      end
   endtask

   task automatic record_tx(input int ncyc);
      pt.delete();
      pb.delete();
      for (int i = 0; i < ncyc; i++) begin
         cycle();
         if (u_transmit) begin
            pt.push_back(cyc);
            pb.push_back(u_tx_byte);
         end
      end
   endtask

   vec_t vt[$];

   initial begin
      bit seen;
      int t0, n_rxr, n_ut;

      reset = 1'b0; enable = 1'b0; cpu_raddr = '0; cpu_waddr = '0;
      cpu_write = 1'b0; cpu_wdata = '0; rx_empty = 1'b1; rx_dout = '0;
      tx_full = 1'b0; u_is_transmitting = 1'b0;
      fifo_sync();
      cpu_raddr = 18'd257;
      cycle();
      cycle();
      check("reset rd_override", rd_override, 0);
      check("reset rd_data", rd_data, 0);
      check("reset rx_read", rx_read, 0);
      check("reset tx_write", tx_write, 0);
      check("reset tx_din", tx_din, 0);
      check("reset tx_read", tx_read, 0);
      check("reset u_transmit", u_transmit, 0);
      check("reset u_tx_byte", u_tx_byte, 0);
      reset = 1'b1;

      //           en rxe rxd    ra   wr wa   wd    txf  rxr ovr rd  txw din
      vt.push_back(mk(1, 0, 'h41, 257, 0, 0,   0,    0,   1, 1, 'h00, 0, 0));
      vt.push_back(mk(1, 0, 'h41, 257, 0, 0,   0,    0,   0, 1, 'h01, 0, 0));
      vt.push_back(mk(1, 0, 'h42, 256, 0, 0,   0,    0,   0, 1, 'h41, 0, 0));
      vt.push_back(mk(1, 0, 'h42, 257, 1, 257, 0,    0,   0, 1, 'h01, 0, 0));
      vt.push_back(mk(1, 0, 'h42, 257, 0, 0,   0,    0,   1, 1, 'h00, 0, 0));
      vt.push_back(mk(1, 0, 'h42, 257, 0, 0,   0,    0,   0, 1, 'h01, 0, 0));
      vt.push_back(mk(1, 0, 'h42, 256, 0, 0,   0,    0,   0, 1, 'h42, 0, 0));
      vt.push_back(mk(1, 1, 'h42, 0,   1, 257, 0,    0,   0, 0, 'h00, 0, 0));
      vt.push_back(mk(1, 0, 'h43, 257, 1, 257, 0,    0,   0, 1, 'h00, 0, 0));
      vt.push_back(mk(1, 0, 'h43, 257, 0, 0,   0,    0,   1, 1, 'h00, 0, 0));
      vt.push_back(mk(1, 0, 'h43, 256, 0, 0,   0,    0,   0, 1, 'h43, 0, 0));
      vt.push_back(mk(1, 0, 'h43, 1,   1, 256, 'h55, 0,   0, 0, 'h00, 1, 'h55));
      vt.push_back(mk(1, 0, 'h43, 259, 1, 256, 'h66, 1,   0, 0, 'h00, 0, 0));
      vt.push_back(mk(1, 0, 'h43, 258, 0, 0,   0,    0,   0, TXSTAT, TXSTAT ? 'h05 : 0, 0, 0));
      vt.push_back(mk(1, 0, 'h43, 258, 1, 258, 0,    0,   0, TXSTAT, TXSTAT ? 'h05 : 0, 0, 0));
      vt.push_back(mk(1, 0, 'h43, 258, 0, 0,   0,    0,   0, TXSTAT, TXSTAT ? 'h01 : 0, 0, 0));
      vt.push_back(mk(0, 0, 'h44, 257, 0, 0,   0,    0,   0, 1, 'h01, 0, 0));
      vt.push_back(mk(0, 0, 'h44, 257, 1, 256, 'h77, 0,   0, 1, 'h00, 0, 0));

      foreach (vt[i]) begin
         enable = vt[i].en; rx_empty = vt[i].rxe; rx_dout = vt[i].rxd;
         cpu_raddr = vt[i].ra; cpu_write = vt[i].wr; cpu_waddr = vt[i].wa;
         cpu_wdata = vt[i].wd; tx_full = vt[i].txf;
         cycle();
         check($sformatf("v%0d rx_read", i), rx_read, vt[i].e_rxr);
         check($sformatf("v%0d rd_override", i), rd_override, vt[i].e_ovr);
         check($sformatf("v%0d rd_data", i), rd_data, vt[i].e_rd);
         check($sformatf("v%0d tx_write", i), tx_write, vt[i].e_txw);
         if (vt[i].e_txw) check($sformatf("v%0d tx_din", i), tx_din, vt[i].e_din);
      end
      cpu_write = 1'b0; tx_full = 1'b0; rx_empty = 1'b1; cpu_raddr = '0;

      // Pacing: three bytes, starts GAP+2 cycles apart, FIFO order.
      enable = 1'b1;
      txq = '{8'hA1, 8'hB2, 8'hC3};
      fifo_sync();
      t0 = cyc;
      record_tx(60);
      check("pace count", pt.size(), 3);
      if (pt.size() == 3) begin
         check("pace first latency", pt[0] - t0, 2);
         check("pace byte0", pb[0], 8'hA1);
         check("pace byte1", pb[1], 8'hB2);
         check("pace byte2", pb[2], 8'hC3);
         check("pace gap01", pt[1] - pt[0], GAP + 2);
         check("pace gap12", pt[2] - pt[1], GAP + 2);
      end
      check("pace fifo drained", txq.size(), 0);

      // Enable drop during GAP with bytes still queued.
      rx_empty = 1'b0; rx_dout = 8'h99;
      txq = '{8'hD4, 8'hE5};
      fifo_sync();
      wait_tx(20, seen);
      check("drop first start", seen, 1);
      check("drop first byte", u_tx_byte, 8'hD4);
      cycle(); cycle(); cycle();
      enable = 1'b0; cpu_raddr = 18'd257;
      n_rxr = 0; n_ut = 0;
      for (int i = 0; i < 40; i++) begin
         cycle();
         if (rx_read) n_rxr++;
         if (u_transmit) n_ut++;
      end
      check("drop no u_transmit", n_ut, 0);
      check("drop no rx_read", n_rxr, 0);
      check("drop avail", rd_data, 0);
      check("drop byte left queued", txq.size(), 1);
      txq.delete();
      fifo_sync();
      rx_empty = 1'b1;

      // Reset during GAP, then a fresh full gap for the following bytes.
      enable = 1'b1;
      txq = '{8'hF6, 8'h17, 8'h28};
      fifo_sync();
      wait_tx(20, seen);
      check("rst first start", seen, 1);
      check("rst first byte", u_tx_byte, 8'hF6);
      cycle(); cycle(); cycle();
      reset = 1'b0; cpu_raddr = 18'd257;
      cycle();
      check("rst mid rd_override", rd_override, 0);
      check("rst mid rd_data", rd_data, 0);
      check("rst mid tx_read", tx_read, 0);
      check("rst mid u_transmit", u_transmit, 0);
      check("rst mid u_tx_byte", u_tx_byte, 0);
      check("rst mid tx_write", tx_write, 0);
      reset = 1'b1;
      t0 = cyc;
      record_tx(40);
      check("rst count", pt.size(), 2);
      if (pt.size() == 2) begin
         check("rst restart latency", pt[0] - t0, 2);
         check("rst byte0", pb[0], 8'h17);
         check("rst byte1", pb[1], 8'h28);
         check("rst gap", pt[1] - pt[0], GAP + 2);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
